// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU and load unit.
// A registered stage drives write_en/addressC/writeBack and doubles as the operand bypass source.
module regfile_wb_arbiter #(
   parameter int unsigned BUS_DATA_WIDTH = 64,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] alu_addr,
   input  logic [BUS_DATA_WIDTH-1:0] alu_data,
   input  logic                      mem_valid,
   output logic                      mem_ready,
   input  logic [REG_ADDR_WIDTH-1:0] mem_addr,
   input  logic [BUS_DATA_WIDTH-1:0] mem_data,
   input  logic                      flush,
   output logic                      write_en,
   output logic [REG_ADDR_WIDTH-1:0] addressC,
   output logic [BUS_DATA_WIDTH-1:0] writeBack,
   output logic                      fwd_valid,
   output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
   output logic [BUS_DATA_WIDTH-1:0] fwd_data,
   output logic [31:0]               wb_count
);

   typedef enum logic {
      PRIO_ALU = 1'b0,
      PRIO_MEM = 1'b1
   } prio_t;

   prio_t                     r_prio;
   prio_t                     w_prio_next;
   logic                      r_write_en;
   logic [REG_ADDR_WIDTH-1:0] r_addr;
   logic [BUS_DATA_WIDTH-1:0] r_data;
   logic [31:0]               r_wb_count;

   logic                      w_grant_alu;
   logic                      w_grant_mem;
   logic                      w_xfer_alu;
   logic                      w_xfer_mem;
   logic                      w_xfer;
   logic [REG_ADDR_WIDTH-1:0] w_sel_addr;
   logic [BUS_DATA_WIDTH-1:0] w_sel_data;
   logic                      w_stage_we;

   always_comb begin
      w_grant_alu = 1'b0;
      w_grant_mem = 1'b0;
      w_sel_addr  = alu_addr;
      w_sel_data  = alu_data;
      w_prio_next = r_prio;

      if (alu_valid && (!mem_valid || r_prio == PRIO_ALU)) begin
         w_grant_alu = 1'b1;
      end else if (mem_valid) begin
         w_grant_mem = 1'b1;
      end

      // Readies are forced low during reset so nothing is consumed before the stage is live.
      w_xfer_alu = w_grant_alu & ~flush & reset_n;
      w_xfer_mem = w_grant_mem & ~flush & reset_n;
      w_xfer     = w_xfer_alu | w_xfer_mem;

      if (w_xfer_mem) begin
         w_sel_addr = mem_addr;
         w_sel_data = mem_data;
      end

      if (flush) begin
         w_prio_next = PRIO_ALU;
      end else if (w_xfer_alu) begin
         w_prio_next = PRIO_MEM;
      end else if (w_xfer_mem) begin
         w_prio_next = PRIO_ALU;
      end

      w_stage_we = w_xfer && (w_sel_addr != '0);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_prio     <= PRIO_ALU;
         r_write_en <= 1'b0;
         r_addr     <= '0;
         r_data     <= '0;
         r_wb_count <= '0;
      end else begin
         r_prio     <= w_prio_next;
         r_write_en <= w_stage_we;
         if (w_xfer) begin
            r_addr <= w_sel_addr;
            r_data <= w_sel_data;
         end
         // A flushed staged write is dropped from the count even though the file sampled it.
         if (r_write_en && !flush) begin
            r_wb_count <= r_wb_count + 32'd1;
         end
      end
   end

   assign alu_ready = w_xfer_alu;
   assign mem_ready = w_xfer_mem;
   assign write_en  = r_write_en;
   assign addressC  = r_addr;
   assign writeBack = r_data;
   assign fwd_valid = r_write_en;
   assign fwd_addr  = r_addr;
   assign fwd_data  = r_data;
   assign wb_count  = r_wb_count;

endmodule
